// File: rtl/cve2_register_file_sb_pkg.sv
// Shared register-file constants, address type and sizing helpers.
package cve2_pkg;

  localparam int unsigned RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;

  // Number of architectural registers for the selected base ISA.
  function automatic int unsigned num_words(bit rv32e);
    return rv32e ? 32'd16 : 32'd32;
  endfunction

  // True for an address that names a real, writable register (not x0, in range).
  function automatic logic addr_live(rf_addr_t addr, int unsigned nw);
    return (addr != '0) && (32'(addr) < nw);
  endfunction

endpackage

// File: rtl/cve2_register_file_sb_if.sv
// X-interface result and reservation handshakes into the register file.
interface cve2_register_file_sb_if import cve2_pkg::*; #(
  parameter int unsigned DataWidth = 32
) ();

  logic                 x_valid;
  logic                 x_ready;
  rf_addr_t             waddr_x;
  logic [DataWidth-1:0] wdata_x;

  logic                 rsv_valid;
  logic                 rsv_ready;
  rf_addr_t             rsv_addr;

  modport master (
    output x_valid, waddr_x, wdata_x, rsv_valid, rsv_addr,
    input  x_ready, rsv_ready
  );

  modport slave (
    input  x_valid, waddr_x, wdata_x, rsv_valid, rsv_addr,
    output x_ready, rsv_ready
  );

endinterface

// File: rtl/cve2_register_file_sb_scoreboard.sv
// Pending-register scoreboard: reservation handshake, clear on X write-back,
// outstanding counter and per-read-port busy lookup.
module cve2_rf_scoreboard import cve2_pkg::*; #(
  parameter int unsigned NumWords       = 32,
  parameter int unsigned NumReadPorts   = 3,
  parameter int unsigned MaxOutstanding = 4,
  localparam int unsigned CntW          = $clog2(MaxOutstanding + 1)
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          rsv_valid_i,
  input  rf_addr_t                      rsv_addr_i,
  output logic                          rsv_ready_o,
  input  logic                          clr_i,       // fired X write to a live register
  input  rf_addr_t                      clr_addr_i,
  input  rf_addr_t [NumReadPorts-1:0]   raddr_i,
  output logic [NumReadPorts-1:0]       rbusy_o,
  output logic [CntW-1:0]               outstanding_o
);

  localparam int unsigned AW = $clog2(NumWords);

  logic [NumWords-1:0] pending_q, pending_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                rsv_live, rsv_eff, clr_hit, clr_eff, slot_free;

  // Handshake and next-state; a same-cycle clear frees both the bit and a slot.
  always_comb begin
    rsv_live    = addr_live(rsv_addr_i, NumWords);
    clr_hit     = clr_i && (clr_addr_i[AW-1:0] == rsv_addr_i[AW-1:0]);
    clr_eff     = clr_i && pending_q[clr_addr_i[AW-1:0]];
    slot_free   = (cnt_q < CntW'(MaxOutstanding)) || clr_eff;
    rsv_ready_o = !rsv_live ||
                  ((!pending_q[rsv_addr_i[AW-1:0]] || clr_hit) && slot_free);
    rsv_eff     = rsv_valid_i && rsv_ready_o && rsv_live;

    pending_d = pending_q;
    if (clr_i)   pending_d[clr_addr_i[AW-1:0]] = 1'b0;
    if (rsv_eff) pending_d[rsv_addr_i[AW-1:0]] = 1'b1;

    cnt_d = cnt_q;
    if (rsv_eff && !clr_eff)      cnt_d = cnt_q + CntW'(1);
    else if (!rsv_eff && clr_eff) cnt_d = cnt_q - CntW'(1);
  end

  // Scoreboard state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pending_q <= '0;
      cnt_q     <= '0;
    end else begin
      pending_q <= pending_d;
      cnt_q     <= cnt_d;
    end
  end

  // Busy lookup from registered state only.
  always_comb begin
    for (int unsigned p = 0; p < NumReadPorts; p++) begin
      rbusy_o[p] = addr_live(raddr_i[p], NumWords) && pending_q[raddr_i[p][AW-1:0]];
    end
  end

  assign outstanding_o = cnt_q;

endmodule

// File: rtl/cve2_register_file_sb.sv
// Flip-flop register file with a core write port, an X-interface write port and
// an integrated reservation scoreboard for offloaded instructions.
module cve2_register_file_sb import cve2_pkg::*; #(
  parameter bit                   RV32E          = 1'b0,
  parameter int unsigned          DataWidth      = 32,
  parameter logic [DataWidth-1:0] WordZeroVal    = '0,
  parameter int unsigned          NumReadPorts   = 3,
  parameter bit                   WriteBypass    = 1'b0,
  parameter int unsigned          MaxOutstanding = 4,
  localparam int unsigned         CntW           = $clog2(MaxOutstanding + 1)
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  test_en_i,
  input  rf_addr_t [NumReadPorts-1:0]           raddr_i,
  output logic [NumReadPorts-1:0][DataWidth-1:0] rdata_o,
  output logic [NumReadPorts-1:0]               rbusy_o,
  input  rf_addr_t                              waddr_a_i,
  input  logic [DataWidth-1:0]                  wdata_a_i,
  input  logic                                  we_a_i,
  cve2_register_file_sb_if.slave                xif_io,
  output logic [CntW-1:0]                       outstanding_o
);

  localparam int unsigned NumWords = num_words(RV32E);
  localparam int unsigned AW       = $clog2(NumWords);

  logic [DataWidth-1:0] rf_q    [1:NumWords-1];
  logic [DataWidth-1:0] rf_d    [1:NumWords-1];
  logic [DataWidth-1:0] rf_view [NumWords];
  logic                 we_a_live, x_fire, x_live;

  logic unused_test_en;
  assign unused_test_en = test_en_i;

  // Port arbitration: the core write port wins an address collision.
  always_comb begin
    xif_io.x_ready = !(we_a_i && (waddr_a_i == xif_io.waddr_x));
    we_a_live      = we_a_i && addr_live(waddr_a_i, NumWords);
    x_fire         = xif_io.x_valid && xif_io.x_ready;
    x_live         = x_fire && addr_live(xif_io.waddr_x, NumWords);
  end

  // Write decode; A and X can only hit the same register when X is stalled.
  always_comb begin
    for (int unsigned i = 1; i < NumWords; i++) begin
      rf_d[i] = rf_q[i];
      if (we_a_live && (waddr_a_i[AW-1:0] == AW'(i))) begin
        rf_d[i] = wdata_a_i;
      end else if (x_live && (xif_io.waddr_x[AW-1:0] == AW'(i))) begin
        rf_d[i] = xif_io.wdata_x;
      end
    end
  end

  // Data flops for x1..x(NumWords-1).
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 1; i < NumWords; i++) rf_q[i] <= WordZeroVal;
    end else begin
      for (int unsigned i = 1; i < NumWords; i++) rf_q[i] <= rf_d[i];
    end
  end

  // Full-size read view with x0 tied to the zero value.
  always_comb begin
    rf_view[0] = WordZeroVal;
    for (int unsigned i = 1; i < NumWords; i++) rf_view[i] = rf_q[i];
  end

  // Read muxes with optional same-cycle forwarding (A before X).
  always_comb begin
    for (int unsigned p = 0; p < NumReadPorts; p++) begin
      rdata_o[p] = WordZeroVal;
      if (addr_live(raddr_i[p], NumWords)) begin
        rdata_o[p] = rf_view[raddr_i[p][AW-1:0]];
        if (WriteBypass) begin
          if (we_a_live && (waddr_a_i == raddr_i[p])) begin
            rdata_o[p] = wdata_a_i;
          end else if (x_live && (xif_io.waddr_x == raddr_i[p])) begin
            rdata_o[p] = xif_io.wdata_x;
          end
        end
      end
    end
  end

  cve2_rf_scoreboard #(
    .NumWords       (NumWords),
    .NumReadPorts   (NumReadPorts),
    .MaxOutstanding (MaxOutstanding)
  ) u_scoreboard (
    .clk_i         (clk_i),
    .rst_ni        (rst_ni),
    .rsv_valid_i   (xif_io.rsv_valid),
    .rsv_addr_i    (xif_io.rsv_addr),
    .rsv_ready_o   (xif_io.rsv_ready),
    .clr_i         (x_live),
    .clr_addr_i    (xif_io.waddr_x),
    .raddr_i       (raddr_i),
    .rbusy_o       (rbusy_o),
    .outstanding_o (outstanding_o)
  );

endmodule

// File: tb/tb_cve2_register_file_sb.sv
// Bench: two instances (RV32I no-bypass, RV32E bypass) share one stimulus
// stream; a per-instance array model predicts every output each cycle.
module tb_cve2_register_file_sb;
  import cve2_pkg::*;

  localparam int unsigned NRP    = 3;
  localparam int unsigned DW     = 32;
  localparam int          MaxOut = 4;

  logic                  clk = 1'b0;
  logic                  rst_n;
  logic                  test_en = 1'b0;
  rf_addr_t [NRP-1:0]    raddr;
  logic                  we_a;
  rf_addr_t              waddr_a;
  logic [DW-1:0]         wdata_a;
  logic                  x_valid;
  rf_addr_t              waddr_x;
  logic [DW-1:0]         wdata_x;
  logic                  rsv_valid;
  rf_addr_t              rsv_addr;

  logic [NRP-1:0][DW-1:0] rdata0, rdata1;
  logic [NRP-1:0]         rbusy0, rbusy1;
  logic [2:0]             outst0, outst1;

  cve2_register_file_sb_if #(.DataWidth(DW)) xif0 ();
  cve2_register_file_sb_if #(.DataWidth(DW)) xif1 ();

  assign xif0.x_valid = x_valid;   assign xif1.x_valid = x_valid;
  assign xif0.waddr_x = waddr_x;   assign xif1.waddr_x = waddr_x;
  assign xif0.wdata_x = wdata_x;   assign xif1.wdata_x = wdata_x;
  assign xif0.rsv_valid = rsv_valid; assign xif1.rsv_valid = rsv_valid;
  assign xif0.rsv_addr = rsv_addr; assign xif1.rsv_addr = rsv_addr;

  cve2_register_file_sb #(
    .RV32E(1'b0), .DataWidth(DW), .NumReadPorts(NRP), .WriteBypass(1'b0), .MaxOutstanding(MaxOut)
  ) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata0),
    .rbusy_o(rbusy0), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .xif_io(xif0), .outstanding_o(outst0)
  );

  cve2_register_file_sb #(
    .RV32E(1'b1), .DataWidth(DW), .NumReadPorts(NRP), .WriteBypass(1'b1), .MaxOutstanding(MaxOut)
  ) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .raddr_i(raddr), .rdata_o(rdata1),
    .rbusy_o(rbusy1), .waddr_a_i(waddr_a), .wdata_a_i(wdata_a), .we_a_i(we_a),
    .xif_io(xif1), .outstanding_o(outst1)
  );

  always #5 clk = ~clk;

  // Reference model state per instance.
  logic [DW-1:0] mreg  [2][32];
  bit            mpend [2][32];
  int            n_checks = 0;
  int            n_fail   = 0;

  function automatic int nw(int k);
    return (k == 1) ? 16 : 32;
  endfunction

  function automatic bit live(int k, int a);
    return (a != 0) && (a < nw(k));
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 2; k++)
      for (int a = 0; a < 32; a++) begin
        mreg[k][a]  = '0;
        mpend[k][a] = 1'b0;
      end
  endtask

  task automatic idle();
    raddr = '0; we_a = 0; waddr_a = '0; wdata_a = '0;
    x_valid = 0; waddr_x = '0; wdata_x = '0; rsv_valid = 0; rsv_addr = '0;
  endtask

  // Settle, compare every output of both instances, then advance the model.
  task automatic cyc();
    bit            exp_xr, a_eff, x_eff, exp_rr, r_eff;
    bit            pa [32];
    int            cnt_now, cnt_after;
    logic [DW-1:0] exp_rd;
    #1;
    exp_xr = !(we_a && (waddr_a == waddr_x));
    for (int k = 0; k < 2; k++) begin
      a_eff = we_a && live(k, int'(waddr_a));
      x_eff = x_valid && exp_xr && live(k, int'(waddr_x));
      cnt_now = 0; cnt_after = 0;
      for (int a = 0; a < 32; a++) begin
        pa[a] = mpend[k][a];
        cnt_now += int'(mpend[k][a]);
      end
      if (x_eff) pa[waddr_x] = 1'b0;
      for (int a = 0; a < 32; a++) cnt_after += int'(pa[a]);
      exp_rr = !live(k, int'(rsv_addr)) || (!pa[rsv_addr] && (cnt_after < MaxOut));
      check($sformatf("k%0d x_ready", k), (k == 0) ? xif0.x_ready : xif1.x_ready, exp_xr);
      check($sformatf("k%0d rsv_ready a%0d", k, rsv_addr),
            (k == 0) ? xif0.rsv_ready : xif1.rsv_ready, exp_rr);
      check($sformatf("k%0d outstanding", k), (k == 0) ? outst0 : outst1, cnt_now);
      for (int p = 0; p < int'(NRP); p++) begin
        exp_rd = '0;
        if (live(k, int'(raddr[p]))) begin
          exp_rd = mreg[k][raddr[p]];
          if (k == 1 && a_eff && waddr_a == raddr[p]) exp_rd = wdata_a;
          else if (k == 1 && x_eff && waddr_x == raddr[p]) exp_rd = wdata_x;
        end
        check($sformatf("k%0d rdata p%0d a%0d", k, p, raddr[p]),
              (k == 0) ? rdata0[p] : rdata1[p], exp_rd);
        check($sformatf("k%0d rbusy p%0d a%0d", k, p, raddr[p]),
              (k == 0) ? rbusy0[p] : rbusy1[p],
              live(k, int'(raddr[p])) && mpend[k][raddr[p]]);
      end
      if (rst_n) begin
        r_eff = rsv_valid && exp_rr && live(k, int'(rsv_addr));
        if (x_eff) begin
          mreg[k][waddr_x]  = wdata_x;
          mpend[k][waddr_x] = 1'b0;
        end
        if (a_eff) mreg[k][waddr_a] = wdata_a;
        if (r_eff) mpend[k][rsv_addr] = 1'b1;
      end
    end
  endtask

  function automatic rf_addr_t rand_addr();
    return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 11));
  endfunction

  initial begin
    rst_n = 1'b0;
    idle();
    model_clear();
    repeat (2) @(negedge clk);
    cyc();
    @(negedge clk);
    rst_n = 1'b1;

    // Reset sweep of all addresses.
    for (int a = 0; a < 32; a++) begin
      @(negedge clk); idle();
      raddr = {5'(a), 5'(a), 5'(a)};
      cyc();
      check("rst_rd", rdata0[0], 0);
      check("rst_busy", rbusy0[0], 0);
    end
    check("rst_outst", outst0, 0);

    // Core write of x5, bypass vs no-bypass, then x0 write.
    @(negedge clk); idle();
    we_a = 1; waddr_a = 5'd5; wdata_a = 32'hDEADBEEF; raddr[0] = 5'd5;
    cyc();
    check("x5_same_nobyp", rdata0[0], 0);
    check("x5_same_byp", rdata1[0], 32'hDEADBEEF);
    @(negedge clk); idle(); raddr[0] = 5'd5; cyc();
    check("x5_next", rdata0[0], 32'hDEADBEEF);
    @(negedge clk); idle(); we_a = 1; waddr_a = '0; wdata_a = 32'hFFFFFFFF; cyc();
    @(negedge clk); idle(); raddr[1] = '0; cyc();
    check("x0_rd", rdata0[1], 0);

    // Fill the scoreboard, hit the limit, clear one entry.
    for (int r = 7; r <= 10; r++) begin
      @(negedge clk); idle(); rsv_valid = 1; rsv_addr = 5'(r); cyc();
    end
    @(negedge clk); idle(); rsv_valid = 1; rsv_addr = 5'd11; cyc();
    check("full_outst", outst0, 4);
    check("full_rsv_ready", xif0.rsv_ready, 0);
    @(negedge clk); idle(); x_valid = 1; waddr_x = 5'd8; wdata_x = 32'h88; rsv_addr = 5'd11; cyc();
    @(negedge clk); idle(); rsv_addr = 5'd11; raddr[2] = 5'd8; cyc();
    check("clr_outst", outst0, 3);
    check("clr_rsv_ready", xif0.rsv_ready, 1);
    check("clr_busy", rbusy0[2], 0);

    // A/X collision on x12 while x12 is reserved.
    @(negedge clk); idle(); rsv_valid = 1; rsv_addr = 5'd12; cyc();
    @(negedge clk); idle();
    we_a = 1; waddr_a = 5'd12; wdata_a = 32'h1; x_valid = 1; waddr_x = 5'd12; wdata_x = 32'h2;
    cyc();
    check("coll_x_ready", xif0.x_ready, 0);
    @(negedge clk); idle(); x_valid = 1; waddr_x = 5'd12; wdata_x = 32'h2; raddr[0] = 5'd12; cyc();
    check("coll_a_won", rdata0[0], 32'h1);
    @(negedge clk); idle(); raddr[0] = 5'd12; cyc();
    check("coll_x_done", rdata0[0], 32'h2);
    check("coll_busy", rbusy0[0], 0);
    for (int r = 7; r <= 10; r++) begin
      @(negedge clk); idle(); x_valid = 1; waddr_x = 5'(r); wdata_x = $urandom(); cyc();
    end

    // Same-cycle re-reservation and clear of x3.
    @(negedge clk); idle(); rsv_valid = 1; rsv_addr = 5'd3; cyc();
    @(negedge clk); idle();
    rsv_valid = 1; rsv_addr = 5'd3; x_valid = 1; waddr_x = 5'd3; wdata_x = 32'h33;
    cyc();
    check("rc_rsv_ready", xif0.rsv_ready, 1);
    @(negedge clk); idle(); raddr[0] = 5'd3; cyc();
    check("rc_busy", rbusy0[0], 1);
    check("rc_outst", outst0, 1);

    // RV32E out-of-range write and reservation.
    @(negedge clk); idle(); we_a = 1; waddr_a = 5'd20; wdata_a = 32'hCAFE; cyc();
    @(negedge clk); idle(); raddr[0] = 5'd20; rsv_valid = 1; rsv_addr = 5'd20; cyc();
    check("e_rd20", rdata1[0], 0);
    check("e_rsv20_ready", xif1.rsv_ready, 1);
    @(negedge clk); idle(); cyc();
    check("e_outst", outst1, 1);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (i == 1500) begin
        rst_n = 1'b0;
        model_clear();
      end
      if (i == 1503) rst_n = 1'b1;
      raddr     = {rand_addr(), rand_addr(), rand_addr()};
      we_a      = ($urandom_range(0, 9) < 4);
      waddr_a   = rand_addr();
      wdata_a   = $urandom();
      x_valid   = ($urandom_range(0, 9) < 4);
      waddr_x   = rand_addr();
      wdata_x   = $urandom();
      rsv_valid = ($urandom_range(0, 9) < 4);
      rsv_addr  = rand_addr();
      cyc();
    end

    @(negedge clk); idle(); rst_n = 1'b0; model_clear(); cyc();
    check("end_rst_outst0", outst0, 0);
    check("end_rst_outst1", outst1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
